div_iter: RTL and testbench
===========================

// Module: div_iter
// PURPOSE
//  Iterative radix-2 restoring divider for MIPS DIV/DIVU in the execute stage.
//  - The ALU launches it and holds the E stage with stall_div until the result is ready.
//  - The 64-bit {remainder, quotient} result is registered into M and written to HI/LO there.
//  - One quotient bit per cycle; the pipeline holds all operands stable during the stall.
// PARAMETERS
//  WIDTH  32  operand width; quotient and remainder are each WIDTH bits
// PORTS
//  clk         in   1        clock, rising edge
//  rst         in   1        reset, asynchronous, active-high
//  start       in   1        DIV/DIVU is in E (level; the decoded ALU op)
//  signed_div  in   1        1 = DIV (signed), 0 = DIVU
//  annul       in   1        flushE: abort any divide in progress
//  dividend    in   WIDTH    rs value (forwarded)
//  divisor     in   WIDTH    rt value (forwarded)
//  result      out  2*WIDTH  {remainder -> HI, quotient -> LO}
//  ready       out  1        1-cycle pulse: result valid this cycle
//  stall_div   out  1        hold F/D/E and bubble M while high
// BEHAVIOUR
//  - Reset (async): state=IDLE, cnt=0, result=0, ready=0, stall_div=0.
//  - FSM states: IDLE, BUSY, DONE.
//    - IDLE & start & ~annul:
//      - Latch |dividend| and |divisor| (magnitudes when signed_div, raw otherwise).
//      - Latch sign_q = a[31]^b[31] and sign_r = a[31]; both are forced to 0 when ~signed_div.
//      - Go to BUSY with cnt=0.
//    - BUSY: perform one step per cycle, cnt++. After the step with cnt==WIDTH-1, go to DONE.
//    - DONE: apply the sign fix to the quotient and remainder, load result, ready=1.
//      Always return to IDLE. start is ignored here: it is the same instruction leaving E.
//    - annul in any state: go to IDLE next cycle. result is not updated and ready stays 0.
//  - Step (restoring): {r,q} <<= 1; if r >= d then r -= d and q[0] = 1.
//    The partial remainder is WIDTH+1 bits wide so the compare has no overflow.
//  - Sign fix: quotient is negated if sign_q; remainder is negated if sign_r.
//    Division truncates toward zero; the remainder takes the sign of the dividend.
//  - stall_div = (IDLE & start & ~annul) | BUSY. It is combinational and low in DONE.
//  - Latency: start seen at cycle t.
//    - stall_div is high in cycles t..t+WIDTH.
//    - ready and the new result appear at t+WIDTH+1.
//    - Total is WIDTH+2 cycles.
//  - result holds its last value until the next DONE.
//  - Divisor 0 gives quotient = all-ones and remainder = dividend, for both signedness modes.
//  - 0x8000_0000 / -1 (signed) gives quotient 0x8000_0000 and remainder 0; no trap.
//  - Back-to-back divides: the second one starts in the IDLE cycle after DONE.
// CONFIGURATION
//  - Macro DIV_FAST_ZERO_EN.
//  - Defined: in IDLE, start with divisor==0 goes straight to DONE.
//    - stall_div is high for 1 cycle only; the result is the same divide-by-zero value.
//  - Undefined: a zero divisor runs the full WIDTH iterations.
//    - The result is forced to the divide-by-zero value in DONE.
// STRUCTURE
//  - Shared defines.vh:
//    - DIV_IDLE/DIV_BUSY/DIV_DONE state encodings.
//    - The ALU control codes for DIV/DIVU that drive start and signed_div.
//  - Sub-module div_step: combinational single restoring step.
//    - Inputs: {r, q, d}. Outputs: {r', q'}.
//  - The FSM, counter and sign fix stay in div_iter.
// TESTING
//  - DIVU 100 / 7: stall_div high 33 cycles, then ready with result = {32'd2, 32'd14}.
//  - DIV -7 / 2: result = {32'hFFFF_FFFF, 32'hFFFF_FFFD}, i.e. rem -1, quot -3.
//  - DIV 0x8000_0000 / 0xFFFF_FFFF: result = {32'h0, 32'h8000_0000}.
//  - DIVU 5 / 0: result = {32'd5, 32'hFFFF_FFFF}.
//    - With DIV_FAST_ZERO_EN, stall_div is high 1 cycle; without it, 33 cycles.
//  - Annul mid-divide:
//    - annul at BUSY cnt=10 -> IDLE next cycle, stall_div=0, no ready, result unchanged.
//    - A new DIVU 9 / 3 then gives {0, 3}.
//  - Reset mid-divide: rst asserted async at cnt=20 -> outputs 0 immediately.
//    - After release with start held high, a full 33-cycle divide restarts.

Source files
------------

// File: rtl/div_iter_pkg.sv
// div_iter_pkg: shared state encoding for the iterative divider
package div_iter_pkg;
   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } divState_t;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rIn,
   input  logic [WIDTH-1:0] qIn,
   input  logic [WIDTH-1:0] dIn,
   output logic [WIDTH-1:0] rOut,
   output logic [WIDTH-1:0] qOut
);
   logic [WIDTH:0] shifted;
   logic [WIDTH-1:0] diff;
   logic fits;
   assign shifted = {rIn, qIn[WIDTH-1]};
   assign fits = shifted >= {1'b0, dIn};
   assign diff = shifted[WIDTH-1:0] - dIn;
   assign rOut = fits ? diff : shifted[WIDTH-1:0];
   assign qOut = {qIn[WIDTH-2:0], fits};
endmodule

// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider for DIV/DIVU; DIV_FAST_ZERO_EN skips iterations on a zero divisor
import div_iter_pkg::*;
module div_iter #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               signed_div,
   input  logic               annul,
   input  logic [WIDTH-1:0]   dividend,
   input  logic [WIDTH-1:0]   divisor,
   output logic [2*WIDTH-1:0] result,
   output logic               ready,
   output logic               stall_div
);
   localparam int CW = $clog2(WIDTH);
   divState_t state, nextState;
   logic [CW-1:0] cnt;
   logic [WIDTH-1:0] remReg, quoReg, divReg, dvdReg, remNext, quoNext, remFix, quoFix, magA, magB;
   logic [2*WIDTH-1:0] resultReg, fixedRes;
   logic signQ, signR, launch, lastStep, fastZero;
   div_step #(.WIDTH(WIDTH)) uStep (
      .rIn(remReg), .qIn(quoReg), .dIn(divReg), .rOut(remNext), .qOut(quoNext)
   );
`ifdef DIV_FAST_ZERO_EN
   assign fastZero = divisor == '0;
`else
   assign fastZero = 1'b0;
`endif
   assign launch = state == DIV_IDLE & start & ~annul;
   assign magA = (signed_div & dividend[WIDTH-1]) ? -dividend : dividend;
   assign magB = (signed_div & divisor[WIDTH-1]) ? -divisor : divisor;
   assign lastStep = cnt == CW'(WIDTH - 1);
   assign quoFix = signQ ? -quoReg : quoReg;
   assign remFix = signR ? -remReg : remReg;
   assign fixedRes = (divReg == '0) ? {dvdReg, {WIDTH{1'b1}}} : {remFix, quoFix};
   assign ready = state == DIV_DONE & ~annul;
   assign result = ready ? fixedRes : resultReg;
   assign stall_div = ~rst & (launch | state == DIV_BUSY);
   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= DIV_IDLE;
      else state <= nextState;
   end
   // next state: annul wins everywhere, DONE always falls back to IDLE
   always_comb begin
      nextState = state;
      if (annul) nextState = DIV_IDLE;
      else if (state == DIV_IDLE && start) nextState = fastZero ? DIV_DONE : DIV_BUSY;
      else if (state == DIV_BUSY && lastStep) nextState = DIV_DONE;
      else if (state == DIV_DONE) nextState = DIV_IDLE;
   end
   // operand latch, one quotient bit per BUSY cycle, result capture on ready
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         remReg <= '0;
         quoReg <= '0;
         divReg <= '0;
         dvdReg <= '0;
         signQ <= 1'b0;
         signR <= 1'b0;
         resultReg <= '0;
      end else begin
         if (launch) begin
            cnt <= '0;
            remReg <= '0;
            quoReg <= magA;
            divReg <= magB;
            dvdReg <= dividend;
            signQ <= signed_div & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            signR <= signed_div & dividend[WIDTH-1];
         end else if (state == DIV_BUSY) begin
            cnt <= cnt + CW'(1);
            remReg <= remNext;
            quoReg <= quoNext;
         end
         if (ready) resultReg <= fixedRes;
      end
   end
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed checks of div_iter latency, signs, divide-by-zero, annul and reset
module tb_div_iter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic signed_div = 1'b0;
   logic annul = 1'b0;
   logic [31:0] dividend = '0;
   logic [31:0] divisor = '0;
   logic [63:0] result;
   logic ready;
   logic stall_div;
   int checks = 0;
   int errors = 0;
   logic [63:0] lastRes = '0;
`ifdef DIV_FAST_ZERO_EN
   localparam int ZS = 1;
`else
   localparam int ZS = 33;
`endif
   div_iter dut (
      .clk(clk), .rst(rst), .start(start), .signed_div(signed_div), .annul(annul),
      .dividend(dividend), .divisor(divisor), .result(result), .ready(ready), .stall_div(stall_div)
   );
   always #5 clk = ~clk;
   task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", tag, obs, exp);
      end
   endtask
   task automatic waitResult(input string tag, input int expStalls, input logic [63:0] expRes);
      int stalls = 0;
      logic got = 1'b0;
      logic [63:0] res = '0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         if (ready) begin
            got = 1'b1;
            res = result;
         end else begin
            if (stall_div) stalls++;
            @(posedge clk);
            #1;
         end
      end
      checkVal({tag, "_ready"}, 64'(got), 64'd1);
      checkVal({tag, "_stalls"}, 64'(stalls), 64'(expStalls));
      checkVal({tag, "_result"}, res, expRes);
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      checkVal({tag, "_hold"}, result, expRes);
      checkVal({tag, "_readyLow"}, 64'(ready), 64'd0);
      lastRes = expRes;
   endtask
   task automatic runDiv(input string tag, input logic sd, input logic [31:0] a, input logic [31:0] b,
                         input int expStalls, input logic [63:0] expRes);
      @(posedge clk);
      #1;
      start = 1'b1;
      signed_div = sd;
      dividend = a;
      divisor = b;
      waitResult(tag, expStalls, expRes);
   endtask
   initial begin
      int readies;
      repeat (2) @(posedge clk);
      #1;
      checkVal("rst_result", result, 64'd0);
      checkVal("rst_ready", 64'(ready), 64'd0);
      checkVal("rst_stall", 64'(stall_div), 64'd0);
      rst = 1'b0;
      runDiv("divu_100_7", 1'b0, 32'd100, 32'd7, 33, {32'd2, 32'd14});
      runDiv("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      runDiv("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'h0, 32'h8000_0000});
      runDiv("divu_5_0", 1'b0, 32'd5, 32'd0, ZS, {32'd5, 32'hFFFF_FFFF});
      runDiv("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, ZS, {32'hFFFF_FFFB, 32'hFFFF_FFFF});
      runDiv("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, {32'd1, 32'hFFFF_FFFD});
      runDiv("div_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 33, {32'hFFFF_FFFE, 32'd14});
      runDiv("divu_max_2", 1'b0, 32'hFFFF_FFFF, 32'd2, 33, {32'd1, 32'h7FFF_FFFF});
      @(posedge clk);
      #1;
      start = 1'b1;
      signed_div = 1'b0;
      dividend = 32'd1000;
      divisor = 32'd3;
      repeat (11) @(posedge clk);
      #1;
      annul = 1'b1;
      start = 1'b0;
      @(posedge clk);
      #1;
      annul = 1'b0;
      @(negedge clk);
      checkVal("annul_stall", 64'(stall_div), 64'd0);
      checkVal("annul_ready", 64'(ready), 64'd0);
      checkVal("annul_result", result, lastRes);
      readies = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (ready) readies++;
      end
      checkVal("annul_noReady", 64'(readies), 64'd0);
      checkVal("annul_keep", result, lastRes);
      runDiv("divu_9_3", 1'b0, 32'd9, 32'd3, 33, {32'd0, 32'd3});
      @(posedge clk);
      #1;
      start = 1'b1;
      signed_div = 1'b0;
      dividend = 32'd100;
      divisor = 32'd7;
      repeat (21) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkVal("rstMid_result", result, 64'd0);
      checkVal("rstMid_stall", 64'(stall_div), 64'd0);
      checkVal("rstMid_ready", 64'(ready), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      waitResult("rstRestart", 33, {32'd2, 32'd14});
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
